// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with optional return-address stack.
// Per-cycle priority: rst > stall > ret > branch/call > sequential increment.
// Build option: define PC_SEQ_RAS_EN to compile in the return-address stack.
// Without that macro, ret is ignored, br_call is an ordinary branch and the
// stack status outputs are tied to their empty values.
module pc_seq #(
    parameter int            AW        = 8,
    parameter logic [AW-1:0] RESET_VEC = {AW{1'b0}},
    parameter int            RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          br_valid,
    input  logic          br_rel,
    input  logic          br_call,
    input  logic          ret,
    input  logic [AW-1:0] br_target,
    output logic [AW-1:0] pc,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_ovf,
    output logic          ras_unf
);

    logic [AW-1:0] pc_r;
    logic [AW-1:0] pc_nxt_s;
    logic [AW-1:0] pc_inc_s;
    logic [AW-1:0] br_tgt_s;

    // Same-width addition gives the modulo-2^AW wrap, and it also makes a
    // signed offset behave as if it were sign-extended.
    assign pc_inc_s = pc_r + AW'(1);
    assign br_tgt_s = br_rel ? (pc_r + br_target) : br_target;
    assign pc       = pc_r;

`ifdef PC_SEQ_RAS_EN
    localparam int            PW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    // The stack is a circular buffer. tp_r indexes the newest entry. When the
    // buffer is full, the slot after the top is the oldest entry, so a push
    // simply overwrites it.
    logic [AW-1:0] ras_r [RAS_DEPTH];
    logic [PW-1:0] tp_r;
    logic [PW-1:0] tp_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          push_s;
    logic          empty_r;
    logic          full_r;
    logic          ovf_r;
    logic          unf_r;
    logic          ovf_nxt_s;
    logic          unf_nxt_s;

    // Next-state selection: ret beats branch/call, and branch/call beats increment
    always_comb begin
        pc_nxt_s  = pc_r;
        tp_nxt_s  = tp_r;
        cnt_nxt_s = cnt_r;
        push_s    = 1'b0;
        ovf_nxt_s = ovf_r;
        unf_nxt_s = unf_r;
        if (ret) begin
            if (cnt_r != CW'(0)) begin
                pc_nxt_s  = ras_r[tp_r];
                tp_nxt_s  = tp_r - PW'(1);
                cnt_nxt_s = cnt_r - CW'(1);
            end else begin
                pc_nxt_s  = pc_inc_s;
                unf_nxt_s = 1'b1;
            end
        end else if (br_valid) begin
            pc_nxt_s = br_tgt_s;
            if (br_call) begin
                push_s   = 1'b1;
                tp_nxt_s = tp_r + PW'(1);
                if (cnt_r == DEPTH_C) begin
                    ovf_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end else begin
                push_s = 1'b0;
            end
        end else begin
            pc_nxt_s = pc_inc_s;
        end
    end

    // Control state: reset clears everything, stall holds everything
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= RESET_VEC;
            tp_r    <= {PW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else if (!stall) begin
            pc_r    <= pc_nxt_s;
            tp_r    <= tp_nxt_s;
            cnt_r   <= cnt_nxt_s;
            empty_r <= (cnt_nxt_s == CW'(0));
            full_r  <= (cnt_nxt_s == DEPTH_C);
            ovf_r   <= ovf_nxt_s;
            unf_r   <= unf_nxt_s;
        end
    end

    // Return-address storage holds data only; the count decides which entries are valid
    always_ff @(posedge clk) begin
        if (!rst && !stall && push_s) begin
            ras_r[tp_nxt_s] <= pc_inc_s;
        end
    end

    assign ras_empty = empty_r;
    assign ras_full  = full_r;
    assign ras_ovf   = ovf_r;
    assign ras_unf   = unf_r;
`else
    logic unused_s;

    // With no stack, ret has no effect and a call is just a branch
    always_comb begin
        pc_nxt_s = pc_r;
        if (br_valid) begin
            pc_nxt_s = br_tgt_s;
        end else begin
            pc_nxt_s = pc_inc_s;
        end
    end

    // Program-counter register: reset loads the vector, stall holds the value
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_VEC;
        end else if (!stall) begin
            pc_r <= pc_nxt_s;
        end
    end

    assign unused_s  = ^{ret, br_call};
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed-vector bench for pc_seq (AW=8, RESET_VEC=0, RAS_DEPTH=4).
// Each stimulus step pushes the expected post-edge state into a queue. A
// monitor process pops one entry after every rising edge and compares it.
// The expected values depend on whether PC_SEQ_RAS_EN is defined.
module tb_pc_seq;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       br_valid;
    logic       br_rel;
    logic       br_call;
    logic       ret;
    logic [7:0] br_target;
    logic [7:0] pc;
    logic       ras_empty;
    logic       ras_full;
    logic       ras_ovf;
    logic       ras_unf;

    typedef struct {
        logic [7:0] pc;
        logic [3:0] fl;   // {empty, full, ovf, unf}
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    pc_seq #(
        .AW(8),
        .RESET_VEC(8'h00),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .br_valid(br_valid),
        .br_rel(br_rel),
        .br_call(br_call),
        .ret(ret),
        .br_target(br_target),
        .pc(pc),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .ras_ovf(ras_ovf),
        .ras_unf(ras_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: after each rising edge, pop one expectation and compare it
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            logic [3:0] fl;
            e  = q.pop_front();
            fl = {ras_empty, ras_full, ras_ovf, ras_unf};
            checks++;
            if (pc !== e.pc) begin
                errors++;
                $display("FAIL %s pc: got %h want %h", e.tag, pc, e.pc);
            end
            checks++;
            if (fl !== e.fl) begin
                errors++;
                $display("FAIL %s flags{e,f,o,u}: got %b want %b", e.tag, fl, e.fl);
            end
        end
    end

    // ctl = {rst, stall, br_valid, br_rel, br_call, ret}
    task automatic step(input string tag, input logic [5:0] ctl, input logic [7:0] tgt,
                        input logic [7:0] pc_ras, input logic [3:0] fl_ras,
                        input logic [7:0] pc_plain);
        exp_t e;
        @(negedge clk);
        {rst, stall, br_valid, br_rel, br_call, ret} = ctl;
        br_target = tgt;
        e.tag = tag;
`ifdef PC_SEQ_RAS_EN
        e.pc = pc_ras;
        e.fl = fl_ras;
`else
        e.pc = pc_plain;
        e.fl = 4'b1000;
`endif
        q.push_back(e);
    endtask

    initial begin
        {rst, stall, br_valid, br_rel, br_call, ret} = 6'b000000;
        br_target = 8'h00;
        //     tag          rst/stl/bv/rel/call/ret  tgt   pc_ras fl_ras   pc_plain
        step("reset",       6'b100000, 8'h00, 8'h00, 4'b1000, 8'h00);
        step("inc1",        6'b000000, 8'h00, 8'h01, 4'b1000, 8'h01);
        step("inc2",        6'b000000, 8'h00, 8'h02, 4'b1000, 8'h02);
        step("inc3",        6'b000000, 8'h00, 8'h03, 4'b1000, 8'h03);
        step("abs_ff",      6'b001000, 8'hFF, 8'hFF, 4'b1000, 8'hFF);
        step("wrap",        6'b000000, 8'h00, 8'h00, 4'b1000, 8'h00);
        step("abs_10",      6'b001000, 8'h10, 8'h10, 4'b1000, 8'h10);
        step("rel_neg",     6'b001100, 8'hFC, 8'h0C, 4'b1000, 8'h0C);
        step("abs_40",      6'b001000, 8'h40, 8'h40, 4'b1000, 8'h40);
        step("abs_20",      6'b001000, 8'h20, 8'h20, 4'b1000, 8'h20);
        step("call_80",     6'b001010, 8'h80, 8'h80, 4'b0000, 8'h80);
        step("ret_21",      6'b000001, 8'h00, 8'h21, 4'b1000, 8'h81);
        step("call1",       6'b001010, 8'h30, 8'h30, 4'b0000, 8'h30);
        step("call2",       6'b001010, 8'h40, 8'h40, 4'b0000, 8'h40);
        step("call3",       6'b001010, 8'h50, 8'h50, 4'b0000, 8'h50);
        step("call4_full",  6'b001010, 8'h60, 8'h60, 4'b0100, 8'h60);
        step("call5_ovf",   6'b001010, 8'h70, 8'h70, 4'b0110, 8'h70);
        step("pop1",        6'b000001, 8'h00, 8'h61, 4'b0010, 8'h71);
        step("pop2",        6'b000001, 8'h00, 8'h51, 4'b0010, 8'h72);
        step("pop3",        6'b000001, 8'h00, 8'h41, 4'b0010, 8'h73);
        step("pop4",        6'b000001, 8'h00, 8'h31, 4'b1010, 8'h74);
        step("pop_unf",     6'b000001, 8'h00, 8'h32, 4'b1011, 8'h75);
        step("stall1",      6'b011011, 8'hEE, 8'h32, 4'b1011, 8'h75);
        step("stall2",      6'b011011, 8'hEE, 8'h32, 4'b1011, 8'h75);
        step("stall3",      6'b011011, 8'hEE, 8'h32, 4'b1011, 8'h75);
        step("rst_stall",   6'b111011, 8'hEE, 8'h00, 4'b1000, 8'h00);
        step("call_50",     6'b001010, 8'h50, 8'h50, 4'b0000, 8'h50);
        step("ret_call",    6'b001011, 8'h90, 8'h01, 4'b1000, 8'h90);
        step("ret_nopush",  6'b000001, 8'h00, 8'h02, 4'b1001, 8'h91);
        step("call_rel",    6'b001110, 8'h10, 8'h12, 4'b0001, 8'hA1);
        step("ret_rel",     6'b000001, 8'h00, 8'h03, 4'b1001, 8'hA2);
        step("rst_call",    6'b101010, 8'h77, 8'h00, 4'b1000, 8'h00);
        step("ret_post",    6'b000001, 8'h00, 8'h01, 4'b1001, 8'h01);
        @(negedge clk);
        {rst, stall, br_valid, br_rel, br_call, ret} = 6'b010000;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
